// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient controller: controller states and bus widths.
// Pure declarations with no logic, so it adds no latency and applies no backpressure.
package fir_pkg;
    localparam int NTAP    = 33;
    localparam int COEFF_W = 16;
    localparam int SMP_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
endpackage

// File: rtl/fir_rate_gen.sv
// Sample-rate divider: strobes en_acc for one cycle, registering the raw sample, every DIV cycles while run is high.
// The first strobe comes DIV cycles after run rises; there is no backpressure, and the counter is held at 0 while run is low.
module fir_rate_gen
    import fir_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [SMP_W-1:0] sample_raw,
    output logic [SMP_W-1:0] sample_reg,
    output logic             en_acc
);
    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            en_acc     <= 1'b0;
            sample_reg <= '0;
        end else begin
            en_acc <= 1'b0;
            if (!run) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt        <= '0;
                en_acc     <= 1'b1;
                sample_reg <= sample_raw;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient-load FSM (IDLE/LOAD/RUN) and coefficient bank, plus the sample-rate strobe for a transposed FIR.
// Coefficient writes land on the edge they are sampled; the block applies no backpressure.
module fir_coeff_ctrl
    import fir_pkg::*;
#(
    parameter int DIV  = 4,
    parameter int NTAP = fir_pkg::NTAP
) (
    input  logic                    iClk_12M,
    input  logic                    iRst,
    input  logic                    iLoadReq,
    input  logic                    iLoadDone,
    input  logic                    iCoeffWrEn,
    input  logic [5:0]              iCoeffAddr,
    input  logic [15:0]             iCoeffData,
    input  logic [2:0]              iFirIn,
    output logic [2:0]              oFirIn,
    output logic                    oEnAcc,
    output logic [16*NTAP-1:0]      oCoeff,
    output logic                    oBusy,
    output logic                    oAddrErr
);
    localparam logic [6:0] ADDR_MAX = 7'(NTAP);

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [COEFF_W*NTAP-1:0] coeff;
    logic                    wr_hit;
    logic                    addr_ok;
    logic                    run_en;
    logic                    addr_err;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (iLoadReq)  state_nxt = ST_LOAD;
            ST_LOAD: if (iLoadDone) state_nxt = ST_RUN;
            ST_RUN:  if (iLoadReq)  state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    assign wr_hit  = (state == ST_LOAD) && iCoeffWrEn;
    assign addr_ok = (iCoeffAddr != 6'd0) && ({1'b0, iCoeffAddr} <= ADDR_MAX);

    // Bank only changes in LOAD, so the filter never sees a coefficient move mid-stream.
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            coeff <= '0;
        end else if (wr_hit && addr_ok) begin
            for (int k = 0; k < NTAP; k++) begin
                if (iCoeffAddr == 6'(k + 1)) coeff[k*COEFF_W +: COEFF_W] <= iCoeffData;
            end
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst)                                              addr_err <= 1'b0;
        else if ((state != ST_LOAD) && (state_nxt == ST_LOAD)) addr_err <= 1'b0;
        else if (wr_hit && !addr_ok)                           addr_err <= 1'b1;
    end

    // Dropping run on the RUN->LOAD edge clears the counter there, so no strobe leaks out.
    assign run_en = (state == ST_RUN) && (state_nxt == ST_RUN);

    fir_rate_gen #(
        .DIV (DIV)
    ) u_rate_gen (
        .clk        (iClk_12M),
        .rst        (iRst),
        .run        (run_en),
        .sample_raw (iFirIn),
        .sample_reg (oFirIn),
        .en_acc     (oEnAcc)
    );

    assign oCoeff   = coeff;
    assign oBusy    = (state == ST_LOAD);
    assign oAddrErr = addr_err;
endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 Parameter DIV, default 4: clock cycles per input sample; legal range 2..255.
REQ-002 Parameter NTAP, default 33: coefficient count.
REQ-003 iClk_12M  input  1  the single clock; all state changes on its rising edge.
REQ-004 iRst  input  1  reset; asynchronous, active-high.
REQ-005 iLoadReq  input  1  request to enter coefficient load; level, sampled each cycle.
REQ-006 iLoadDone  input  1  end of coefficient load; level, sampled each cycle.
REQ-007 iCoeffWrEn  input  1  coefficient write strobe.
REQ-008 iCoeffAddr  input  6  coefficient index; legal 1..NTAP.
REQ-009 iCoeffData  input  16  signed coefficient value.
REQ-010 iFirIn  input  3  signed raw input sample.
REQ-011 oFirIn  output  3  signed registered sample for the transposed filter.
REQ-012 oEnAcc  output  1  one-cycle filter-advance strobe.
REQ-013 oCoeff  output  16*NTAP  coefficient bank; coefficient k occupies bits [16k-1:16(k-1)].
REQ-014 oBusy  output  1  high while in LOAD.
REQ-015 oAddrErr  output  1  sticky flag for an illegal write address.

Function
REQ-016 States: IDLE, LOAD, RUN; encoding 2 bits.
REQ-017 IDLE -> LOAD when iLoadReq=1; otherwise stay in IDLE.
REQ-018 LOAD -> RUN when iLoadDone=1. iLoadDone has priority over iLoadReq when both are high.
REQ-019 RUN -> LOAD when iLoadReq=1; the sample counter clears and oEnAcc is 0 from the next cycle.
REQ-020 Coefficient write: accepted only in LOAD with iCoeffWrEn=1 and iCoeffAddr in 1..NTAP; the slot updates on that edge.
REQ-021 Writes in IDLE or RUN are ignored and set no flag.
REQ-022 A write in LOAD to address 0 or to an address >NTAP changes no slot and sets oAddrErr.
REQ-023 oAddrErr clears only when the FSM enters LOAD.
REQ-024 A write on the same cycle as the LOAD->RUN transition is accepted.
REQ-025 Sample counter: 8-bit; counts 0..DIV-1 only in RUN, then wraps to 0; held at 0 in IDLE and LOAD.
REQ-026 On the edge where the counter wraps from DIV-1 to 0: oFirIn <= iFirIn and oEnAcc <= 1.
REQ-027 On all other edges, oEnAcc <= 0.
REQ-028 oFirIn holds its value between strobes.
REQ-029 First oEnAcc is high in the DIV-th cycle after entering RUN; steady-state period is exactly DIV cycles.
REQ-030 oCoeff is held constant outside LOAD; the filter never sees a coefficient change while oEnAcc strobes.
REQ-031 oBusy is 1 exactly when the state is LOAD (registered state decode).
REQ-032 No arithmetic is performed on data; coefficients and samples pass bit-exact.

Reset
REQ-033 iRst=1 forces, asynchronously, the following values:
- state IDLE
- counter 0
- oEnAcc 0
- oFirIn 0
- all oCoeff slots 0
- oBusy 0
- oAddrErr 0
REQ-034 Reset asserted mid-LOAD or mid-RUN discards all loaded coefficients.
REQ-035 After iRst deasserts, the first transition occurs on the first rising edge on which iLoadReq is sampled.

Structure
REQ-036 Shared package fir_pkg holds:
- the state enumeration
- NTAP
- coefficient width 16
- sample width 3
REQ-037 One sub-module, fir_rate_gen (sample counter plus oEnAcc/oFirIn register), is instantiated once; the FSM and coefficient bank stay in the top.

Verification
REQ-038 Reset then iLoadReq=1 for 1 cycle -> oBusy=1 next cycle, oEnAcc stays 0, all oCoeff=0.
REQ-039 In LOAD, write addr 1 = 0x7FFF and addr 33 = 0x8001, then iLoadDone -> oCoeff[15:0]=0x7FFF, oCoeff[527:512]=0x8001, other slots 0, oBusy=0.
REQ-040 RUN with DIV=4 and iFirIn stepping 1,2,3,-4 per strobe -> oEnAcc pulses at cycles 4, 8, 12, ... after entry; oFirIn equals the iFirIn value sampled at each strobe edge.
REQ-041 In LOAD, write addr 0 and addr 40 -> no slot changes, oAddrErr=1; re-enter LOAD -> oAddrErr=0.
REQ-042 iLoadReq in RUN while counter=2 -> no further oEnAcc; writes accepted; iLoadDone -> first strobe 4 cycles later.
REQ-043 iRst pulsed mid-RUN, asynchronous to the clock -> oEnAcc=0 and oCoeff=0 immediately; state IDLE.
